bsk_com_filter: RTL and testbench

- Input conditioning stage that sits directly upstream of the receiver command board.
- Takes 16 raw command lines from the optocoupler inputs. These are asynchronous and may bounce.
- Synchronises each line, then debounces it with a per-channel consecutive-sample filter on a prescaled sample tick.
- Drives the clean, registered command word into the board's command input, plus sticky per-channel change flags for diagnostics.

---
 rtl/bsk_com_filter_pkg.sv | 28 ++
 rtl/bsk_com_filter_if.sv | 45 ++++
 rtl/bsk_com_filter_ch.sv | 64 ++++++
 rtl/bsk_com_filter.sv | 78 +++++++
 tb/tb_bsk_com_filter.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsk_com_filter_pkg.sv
// -----------------------------------------------------------------------------
// bsk_pkg
// Shared constants for the command input conditioning stage:
//   COM_WIDTH     - number of command lines on the receiver command board
//   DEF_PRESCALE  - default clk cycles per debounce sample tick
//   DEF_FILT_LEN  - default consecutive differing samples to accept a level
//   clog2()       - ceiling log2, used to size counters from parameters
// -----------------------------------------------------------------------------
package bsk_pkg;

    localparam int COM_WIDTH    = 16;
    localparam int DEF_PRESCALE = 50;
    localparam int DEF_FILT_LEN = 8;

    // Ceiling log2 for counter sizing; callers guarantee value >= 2 so the
    // result is always at least 1 bit.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bsk_com_filter_if.sv
// -----------------------------------------------------------------------------
// bsk_com_filter_if
// Signal bundle between the raw optocoupler command lines and the filtered
// command word.
//   iComRaw  - raw asynchronous command lines (active-high)
//   iBl      - output blocking, active-low
//   iClrChg  - one-clk pulse clearing the sticky change flags
//   oCom     - filtered, registered command word
//   oChg     - sticky per-channel change flags
//   oTick    - one-clk strobe per sample tick
// master: the side that drives the raw lines and controls (board / bench)
// slave : the filter itself
// -----------------------------------------------------------------------------
interface bsk_com_filter_if
    import bsk_pkg::*;
#(
    parameter int WIDTH = COM_WIDTH
);

    logic [WIDTH-1:0] iComRaw;
    logic             iBl;
    logic             iClrChg;
    logic [WIDTH-1:0] oCom;
    logic [WIDTH-1:0] oChg;
    logic             oTick;

    modport master (
        output iComRaw,
        output iBl,
        output iClrChg,
        input  oCom,
        input  oChg,
        input  oTick
    );

    modport slave (
        input  iComRaw,
        input  iBl,
        input  iClrChg,
        output oCom,
        output oChg,
        output oTick
    );

endinterface

// File: rtl/bsk_com_filter_ch.sv
// -----------------------------------------------------------------------------
// bsk_com_filter_ch
// One command channel: two-flop synchroniser followed by a consecutive-sample
// debounce filter evaluated only on the shared sample tick.
//   clk     - system clock
//   iRes    - asynchronous active-low reset
//   comRaw  - raw asynchronous command line
//   tick    - one-clk sample strobe from the shared prescaler
//   state   - accepted (debounced) level
//   chgSet  - combinational pulse in the clk where a new level is accepted
// -----------------------------------------------------------------------------
module bsk_com_filter_ch
    import bsk_pkg::*;
#(
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input  logic clk,
    input  logic iRes,
    input  logic comRaw,
    input  logic tick,
    output logic state,
    output logic chgSet
);

    localparam int              CNT_W    = clog2(FILT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);

    logic             syncP0;
    logic             syncP1;
    logic [CNT_W-1:0] cnt;
    logic             differ;

    // Stage p0/p1: plain flop chain, nothing between the stages
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            syncP0 <= 1'b0;
            syncP1 <= 1'b0;
        end else begin
            syncP0 <= comRaw;
            syncP1 <= syncP0;
        end
    end

    assign differ = syncP1 ^ state;
    assign chgSet = tick & differ & (cnt == CNT_LAST);

    // Filter stage: any agreeing sample restarts the run of differing samples
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (tick) begin
            if (!differ) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                state <= syncP1;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bsk_com_filter.sv
// -----------------------------------------------------------------------------
// bsk_com_filter
// Input conditioning for the receiver command board: synchronises and
// debounces WIDTH raw command lines, gates the result with the blocking input
// and keeps sticky per-channel change flags.
//   clk   - system clock (only clock)
//   iRes  - asynchronous active-low reset; all outputs 0 while low
//   bus   - bsk_com_filter_if.slave (iComRaw, iBl, iClrChg in;
//           oCom, oChg, oTick out)
// -----------------------------------------------------------------------------
module bsk_com_filter
    import bsk_pkg::*;
#(
    parameter int WIDTH    = COM_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int FILT_LEN = DEF_FILT_LEN
) (
    input logic                clk,
    input logic                iRes,
    bsk_com_filter_if.slave    bus
);

    localparam int             PS_W    = clog2(PRESCALE);
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]  psCnt;
    logic             tick;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] chgSet;
    logic [WIDTH-1:0] comReg;
    logic [WIDTH-1:0] chgReg;
    logic             tickReg;

    // Shared prescaler: tick is high during the last count of each period
    assign tick = (psCnt == PS_LAST);

    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            psCnt <= '0;
        end else if (tick) begin
            psCnt <= '0;
        end else begin
            psCnt <= psCnt + 1'b1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : gCh
        bsk_com_filter_ch #(
            .FILT_LEN (FILT_LEN)
        ) uCh (
            .clk    (clk),
            .iRes   (iRes),
            .comRaw (bus.iComRaw[i]),
            .tick   (tick),
            .state  (state[i]),
            .chgSet (chgSet[i])
        );
    end

    // Output stage: blocking only gates the word, never the filter or flags.
    // A set in the same clk as a clear wins for that bit.
    always_ff @(posedge clk or negedge iRes) begin
        if (!iRes) begin
            comReg  <= '0;
            chgReg  <= '0;
            tickReg <= 1'b0;
        end else begin
            comReg  <= state & {WIDTH{bus.iBl}};
            chgReg  <= (chgReg & ~{WIDTH{bus.iClrChg}}) | chgSet;
            tickReg <= tick;
        end
    end

    assign bus.oCom  = comReg;
    assign bus.oChg  = chgReg;
    assign bus.oTick = tickReg;

endmodule

// File: tb/tb_bsk_com_filter.sv
// -----------------------------------------------------------------------------
// tb_bsk_com_filter
// Directed bench for bsk_com_filter with PRESCALE=4, FILT_LEN=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_bsk_com_filter;

    localparam int WIDTH    = 16;
    localparam int PRESCALE = 4;
    localparam int FILT_LEN = 3;

    logic clk;
    logic iRes;
    int   nCmp;
    int   nErr;

    bsk_com_filter_if #(.WIDTH(WIDTH)) bus ();

    bsk_com_filter #(
        .WIDTH    (WIDTH),
        .PRESCALE (PRESCALE),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk  (clk),
        .iRes (iRes),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until oTick is seen (i.e. the edge just passed was a tick edge).
    task automatic waitTick(output logic found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (bus.oTick === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic tickSeen;
        tickSeen     = 1'b0;
        iRes         = 1'b0;
        bus.iComRaw  = 16'hFFFF;
        bus.iBl      = 1'b1;
        bus.iClrChg  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.oTick !== 1'b0) tickSeen = 1'b1;
        end
        nCmp++;
        if (bus.oCom !== 16'h0000) begin
            nErr++;
            $display("FAIL reset_oCom: got %h expected 0000", bus.oCom);
        end
        nCmp++;
        if (bus.oChg !== 16'h0000) begin
            nErr++;
            $display("FAIL reset_oChg: got %h expected 0000", bus.oChg);
        end
        nCmp++;
        if (tickSeen !== 1'b0) begin
            nErr++;
            $display("FAIL reset_oTick: got tick=%b expected 0", tickSeen);
        end
    endtask

    task automatic test_accept;
        int rise;
        bus.iComRaw = 16'h0000;
        step(1);
        iRes = 1'b1;
        step(6);
        bus.iComRaw = 16'h0001;
        rise = 0;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (bus.oCom[0] === 1'b1) begin
                rise = k;
                break;
            end
        end
        nCmp++;
        if (rise < 12 || rise > 15) begin
            nErr++;
            $display("FAIL accept_latency: got %0d clk expected 12..15", rise);
        end
        nCmp++;
        if (bus.oChg !== 16'h0001) begin
            nErr++;
            $display("FAIL accept_oChg: got %h expected 0001", bus.oChg);
        end
    endtask

    task automatic test_tick_period;
        logic found;
        int   period;
        waitTick(found);
        for (int r = 0; r < 2; r++) begin
            period = 0;
            for (int k = 1; k <= 10; k++) begin
                step(1);
                if (bus.oTick === 1'b1) begin
                    period = k;
                    break;
                end
            end
            nCmp++;
            if (!found || period != 4) begin
                nErr++;
                $display("FAIL tick_period: got %0d clk expected 4", period);
            end
        end
    endtask

    task automatic test_glitch;
        logic seenCom;
        logic seenChg;
        seenCom     = 1'b0;
        seenChg     = 1'b0;
        bus.iComRaw = 16'h0003;
        step(8);
        bus.iComRaw = 16'h0001;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (bus.oCom[1] !== 1'b0) seenCom = 1'b1;
            if (bus.oChg[1] !== 1'b0) seenChg = 1'b1;
        end
        nCmp++;
        if (seenCom !== 1'b0) begin
            nErr++;
            $display("FAIL glitch_oCom1: got rise=%b expected 0", seenCom);
        end
        nCmp++;
        if (seenChg !== 1'b0) begin
            nErr++;
            $display("FAIL glitch_oChg1: got set=%b expected 0", seenChg);
        end
    endtask

    task automatic test_blocking;
        bus.iBl = 1'b0;
        step(1);
        nCmp++;
        if (bus.oCom !== 16'h0000) begin
            nErr++;
            $display("FAIL block_oCom: got %h expected 0000", bus.oCom);
        end
        nCmp++;
        if (bus.oChg !== 16'h0001) begin
            nErr++;
            $display("FAIL block_oChg: got %h expected 0001", bus.oChg);
        end
        bus.iComRaw = 16'h0003;
        step(20);
        nCmp++;
        if (bus.oChg !== 16'h0003 || bus.oCom !== 16'h0000) begin
            nErr++;
            $display("FAIL block_filter: got oChg=%h oCom=%h expected 0003/0000",
                     bus.oChg, bus.oCom);
        end
        bus.iBl = 1'b1;
        step(1);
        nCmp++;
        if (bus.oCom !== 16'h0003) begin
            nErr++;
            $display("FAIL unblock_oCom: got %h expected 0003", bus.oCom);
        end
    endtask

    task automatic test_change_flags;
        logic found;
        waitTick(found);
        // Edge T0 was a tick edge; bit 2 is accepted on edge T0+12.
        bus.iComRaw = 16'h0007;
        step(11);
        bus.iClrChg = 1'b1;
        step(1);
        bus.iClrChg = 1'b0;
        nCmp++;
        if (!found || bus.oChg !== 16'h0004) begin
            nErr++;
            $display("FAIL chg_set_wins: got %h expected 0004", bus.oChg);
        end
        step(1);
        nCmp++;
        if (bus.oCom !== 16'h0007) begin
            nErr++;
            $display("FAIL chg_oCom: got %h expected 0007", bus.oCom);
        end
        bus.iClrChg = 1'b1;
        step(1);
        bus.iClrChg = 1'b0;
        nCmp++;
        if (bus.oChg !== 16'h0000) begin
            nErr++;
            $display("FAIL chg_clear: got %h expected 0000", bus.oChg);
        end
    endtask

    task automatic test_reset_mid_filter;
        logic found;
        int   rise;
        waitTick(found);
        bus.iComRaw = 16'h000F;
        step(9);
        nCmp++;
        if (!found || bus.oCom !== 16'h0007) begin
            nErr++;
            $display("FAIL midrst_pre: got %h expected 0007", bus.oCom);
        end
        iRes = 1'b0;
        #1;
        nCmp++;
        if (bus.oCom !== 16'h0000 || bus.oChg !== 16'h0000) begin
            nErr++;
            $display("FAIL midrst_async: got oCom=%h oChg=%h expected 0000/0000",
                     bus.oCom, bus.oChg);
        end
        step(1);
        iRes = 1'b1;
        // Prescaler restarts from 0: tick edges at 4, 8, 12 clk after release,
        // acceptance on the third, oCom one clk later.
        rise = 0;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (bus.oCom[3] === 1'b1) begin
                rise = k;
                break;
            end
        end
        nCmp++;
        if (rise != 13) begin
            nErr++;
            $display("FAIL midrst_restart: got %0d clk expected 13", rise);
        end
    endtask

    initial begin
        nCmp        = 0;
        nErr        = 0;
        iRes        = 1'b0;
        bus.iComRaw = '0;
        bus.iBl     = 1'b1;
        bus.iClrChg = 1'b0;
        test_reset();
        test_accept();
        test_tick_period();
        test_glitch();
        test_blocking();
        test_change_flags();
        test_reset_mid_filter();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

endmodule
